// File: rtl/prbs_error_checker_if.sv
// PRBS-7 checker bus: bit strobe, serial data and clear in; lock and error status out.
// master drives enable/data_in/clear; slave (the checker) drives the status outputs.
interface prbs_error_checker_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic                 data_in;
    logic                 clear;
    logic                 locked;
    logic                 error_pulse;
    logic [CNT_WIDTH-1:0] error_count;
    logic                 overflow;
    logic                 error_led;

    modport master (
        output enable, data_in, clear,
        input  locked, error_pulse, error_count, overflow, error_led
    );

    modport slave (
        input  enable, data_in, clear,
        output locked, error_pulse, error_count, overflow, error_led
    );
endinterface

// File: rtl/prbs_error_checker.sv
// Receive-side PRBS-7 (x^7+x^6+1) checker: self-syncs to data_in, then counts bit errors.
// Ports: clk, reset (sync, active-low), bus (slave: enable/data_in/clear in, status out).
module prbs_error_checker #(
    parameter int CNT_WIDTH      = 16,
    parameter int LOCK_COUNT     = 16,
    parameter int WINDOW         = 64,
    parameter int LOSS_THRESHOLD = 8
) (
    input  logic                clk,
    input  logic                reset,
    prbs_error_checker_if.slave bus
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(LOSS_THRESHOLD + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t               state;
    logic [5:0]           sr;
    logic [6:0]           lfsr;
    logic [2:0]           fill;
    logic [GW-1:0]        good;
    logic [WW-1:0]        win;
    logic [EW-1:0]        werr;
    logic                 locked_q;
    logic                 pulse_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 ovf_q;
    logic                 led_q;

    logic          pred;
    logic          mism;
    logic [6:0]    seed;
    logic [EW-1:0] werr_nxt;
    logic          hit;

    assign pred     = lfsr[6] ^ lfsr[5];
    assign mism     = bus.data_in ^ pred;
    assign seed     = {sr, bus.data_in};
    assign werr_nxt = werr + EW'(mism);
    assign hit      = bus.enable && (state == LOCKED) && mism;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= HUNT;
            sr       <= '0;
            lfsr     <= '0;
            fill     <= '0;
            good     <= '0;
            win      <= '0;
            werr     <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            pulse_q <= hit;
            if (bus.enable) begin
                unique case (state)
                    HUNT: begin
                        sr <= seed[5:0];
                        if (fill == 3'd6) begin
                            fill <= '0;
                            // an all-zero seed would lock the generator at zero
                            if (seed != '0) begin
                                lfsr  <= seed;
                                good  <= '0;
                                state <= VERIFY;
                            end
                        end else begin
                            fill <= fill + 3'd1;
                        end
                    end
                    VERIFY: begin
                        lfsr <= {lfsr[5:0], pred};
                        if (mism) begin
                            state <= HUNT;
                            fill  <= '0;
                            good  <= '0;
                        end else if (good == GW'(LOCK_COUNT - 1)) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            good     <= '0;
                            win      <= '0;
                            werr     <= '0;
                        end else begin
                            good <= good + GW'(1);
                        end
                    end
                    LOCKED: begin
                        // free-running: data_in never reloads the lfsr here
                        lfsr <= {lfsr[5:0], pred};
                        if (mism && werr_nxt == EW'(LOSS_THRESHOLD)) begin
                            state    <= HUNT;
                            locked_q <= 1'b0;
                            fill     <= '0;
                            win      <= '0;
                            werr     <= '0;
                        end else if (win == WW'(WINDOW - 1)) begin
                            win  <= '0;
                            werr <= '0;
                        end else begin
                            win  <= win + WW'(1);
                            werr <= werr_nxt;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
            // clear beats a coincident error; the pulse still fires
            if (bus.clear) begin
                count_q <= '0;
                ovf_q   <= 1'b0;
                led_q   <= 1'b0;
            end else if (hit) begin
                led_q <= 1'b1;
                if (&count_q) ovf_q <= 1'b1;
                else          count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.locked      = locked_q;
    assign bus.error_pulse = pulse_q;
    assign bus.error_count = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.error_led   = led_q;
endmodule

// File: tb/tb_prbs_error_checker.sv
// Randomised self-checking bench for prbs_error_checker: two instances, default and
// CNT_WIDTH=4/LOSS_THRESHOLD=64, driven identically and compared to a queue-based model.
module tb_prbs_error_checker;
    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    prbs_error_checker_if #(.CNT_WIDTH(16)) ifa ();
    prbs_error_checker_if #(.CNT_WIDTH(4))  ifb ();

    prbs_error_checker #(
        .CNT_WIDTH(16), .LOCK_COUNT(16), .WINDOW(64), .LOSS_THRESHOLD(8)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    prbs_error_checker #(
        .CNT_WIDTH(4), .LOCK_COUNT(16), .WINDOW(64), .LOSS_THRESHOLD(64)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: per instance, phase 0=hunt 1=verify 2=locked
    localparam int LOCK_N = 16;
    localparam int WIN_N  = 64;
    int  m_ph[2];
    bit  m_hist[2][$];
    int  m_good[2];
    int  m_widx[2];
    int  m_werr[2];
    int  m_cnt[2];
    bit  m_ovf[2];
    bit  m_led[2];
    bit  m_pulse[2];

    function automatic int thr(input int k);
        return (k == 0) ? 8 : 64;
    endfunction

    function automatic int cmax(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    task automatic model_step(input int k, input bit rst, input bit en,
                              input bit d, input bit clr);
        bit p;
        bit e;
        int ones;
        if (!rst) begin
            m_ph[k] = 0; m_hist[k].delete(); m_good[k] = 0;
            m_widx[k] = 0; m_werr[k] = 0; m_cnt[k] = 0;
            m_ovf[k] = 0; m_led[k] = 0; m_pulse[k] = 0;
            return;
        end
        m_pulse[k] = 0;
        if (en) begin
            if (m_ph[k] == 0) begin
                m_hist[k].push_back(d);
                if (m_hist[k].size() == 7) begin
                    ones = 0;
                    foreach (m_hist[k][i]) ones += int'(m_hist[k][i]);
                    if (ones != 0) begin
                        m_ph[k] = 1;
                        m_good[k] = 0;
                    end else begin
                        m_hist[k].delete();
                    end
                end
            end else begin
                // expected bit = bit 7 back xor bit 6 back of the expected sequence
                p = m_hist[k][0] ^ m_hist[k][1];
                m_hist[k].push_back(p);
                void'(m_hist[k].pop_front());
                e = (d != p);
                if (m_ph[k] == 1) begin
                    if (e) begin
                        m_ph[k] = 0;
                        m_hist[k].delete();
                    end else begin
                        m_good[k]++;
                        if (m_good[k] == LOCK_N) begin
                            m_ph[k] = 2; m_widx[k] = 0; m_werr[k] = 0;
                        end
                    end
                end else begin
                    if (e) begin
                        m_pulse[k] = 1;
                        m_werr[k]++;
                        if (!clr) begin
                            m_led[k] = 1;
                            if (m_cnt[k] == cmax(k)) m_ovf[k] = 1;
                            else m_cnt[k]++;
                        end
                    end
                    if (e && m_werr[k] == thr(k)) begin
                        m_ph[k] = 0;
                        m_hist[k].delete();
                    end else begin
                        m_widx[k]++;
                        if (m_widx[k] == WIN_N) begin
                            m_widx[k] = 0; m_werr[k] = 0;
                        end
                    end
                end
            end
        end
        if (clr) begin
            m_cnt[k] = 0; m_ovf[k] = 0; m_led[k] = 0;
        end
    endtask

    task automatic compare_all();
        chk("a_locked", 32'(ifa.locked), 32'(m_ph[0] == 2));
        chk("a_pulse", 32'(ifa.error_pulse), 32'(m_pulse[0]));
        chk("a_count", 32'(ifa.error_count), 32'(m_cnt[0]));
        chk("a_ovf", 32'(ifa.overflow), 32'(m_ovf[0]));
        chk("a_led", 32'(ifa.error_led), 32'(m_led[0]));
        chk("b_locked", 32'(ifb.locked), 32'(m_ph[1] == 2));
        chk("b_pulse", 32'(ifb.error_pulse), 32'(m_pulse[1]));
        chk("b_count", 32'(ifb.error_count), 32'(m_cnt[1]));
        chk("b_ovf", 32'(ifb.overflow), 32'(m_ovf[1]));
        chk("b_led", 32'(ifb.error_led), 32'(m_led[1]));
    endtask

    task automatic step(input bit rst, input bit en, input bit d, input bit clr);
        reset = rst;
        ifa.enable = en; ifa.data_in = d; ifa.clear = clr;
        ifb.enable = en; ifb.data_in = d; ifb.clear = clr;
        @(posedge clk);
        model_step(0, rst, en, d, clr);
        model_step(1, rst, en, d, clr);
        #1;
        compare_all();
    endtask

    // transmitter-side pattern source
    bit [6:0] gen = 7'h7F;

    task automatic tx(input bit en, input bit flip, input bit clr);
        bit b;
        if (en) begin
            b = gen[6] ^ gen[5];
            gen = {gen[5:0], b};
            step(1'b1, 1'b1, b ^ flip, clr);
        end else begin
            step(1'b1, 1'b0, 1'($urandom), clr);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic lock_run(input string tag);
        for (int i = 1; i <= 23; i++) begin
            tx(1'b1, 1'b0, 1'b0);
            if (i == 22) chk({tag, "_pre"}, 32'(ifa.locked), 32'd0);
            if (i == 23) chk(tag, 32'(ifa.locked), 32'd1);
        end
    endtask

    initial begin
        ifa.enable = 0; ifa.data_in = 0; ifa.clear = 0;
        ifb.enable = 0; ifb.data_in = 0; ifb.clear = 0;

        // T1: reset then idle with enable low
        do_reset(3);
        chk("t1_count", 32'(ifa.error_count), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'($urandom), 1'b0);
        chk("t1_idle_locked", 32'(ifa.locked), 32'd0);

        // T6a: all-zero input never seeds the generator
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_zero_a", 32'(ifa.locked), 32'd0);
        chk("t6_zero_b", 32'(ifb.locked), 32'd0);

        // T2: clean lock in 23 bits, then 500 clean bits
        do_reset(2);
        gen = 7'h7F;
        lock_run("t2_lock");
        for (int i = 0; i < 500; i++) tx(1'b1, 1'b0, 1'b0);
        chk("t2_count", 32'(ifa.error_count), 32'd0);

        // T3: single inverted bit
        tx(1'b1, 1'b1, 1'b0);
        chk("t3_pulse", 32'(ifa.error_pulse), 32'd1);
        tx(1'b1, 1'b0, 1'b0);
        chk("t3_pulse_off", 32'(ifa.error_pulse), 32'd0);
        chk("t3_count", 32'(ifa.error_count), 32'd1);
        chk("t3_led", 32'(ifa.error_led), 32'd1);
        chk("t3_locked", 32'(ifa.locked), 32'd1);
        for (int i = 0; i < 100; i++) tx(1'b1, 1'b0, 1'b0);
        chk("t3_count_hold", 32'(ifa.error_count), 32'd1);

        // T4: 8 errors inside one window force loss of lock on instance a
        do_reset(2);
        lock_run("t4_lock");
        for (int e = 0; e < 8; e++) begin
            chk("t4_still_locked", 32'(ifa.locked), 32'd1);
            tx(1'b1, 1'b1, 1'b0);
            tx(1'b1, 1'b0, 1'b0);
            tx(1'b1, 1'b0, 1'b0);
        end
        chk("t4_unlocked", 32'(ifa.locked), 32'd0);
        chk("t4_count", 32'(ifa.error_count), 32'd8);
        chk("t4_b_locked", 32'(ifb.locked), 32'd1);
        do_reset(0);
        // relock: 2 of the 3-bit gaps above were already clean hunt bits
        for (int i = 3; i <= 23; i++) begin
            tx(1'b1, 1'b0, 1'b0);
            if (i == 22) chk("t4_relock_pre", 32'(ifa.locked), 32'd0);
            if (i == 23) chk("t4_relock", 32'(ifa.locked), 32'd1);
        end
        chk("t4_count_kept", 32'(ifa.error_count), 32'd8);

        // T5: saturation on the 4-bit instance, then clear vs coincident error
        do_reset(2);
        lock_run("t5_lock");
        for (int e = 0; e < 17; e++) begin
            tx(1'b1, 1'b1, 1'b0);
            for (int j = 0; j < 7; j++) tx(1'b1, 1'b0, 1'b0);
        end
        chk("t5_sat", 32'(ifb.error_count), 32'd15);
        chk("t5_ovf", 32'(ifb.overflow), 32'd1);
        chk("t5_b_locked", 32'(ifb.locked), 32'd1);
        tx(1'b1, 1'b1, 1'b1);
        chk("t5_clr_count", 32'(ifb.error_count), 32'd0);
        chk("t5_clr_ovf", 32'(ifb.overflow), 32'd0);
        chk("t5_clr_led", 32'(ifb.error_led), 32'd0);
        chk("t5_clr_pulse", 32'(ifb.error_pulse), 32'd1);

        // T6b: 50% enable during lock acquisition
        do_reset(2);
        begin
            int n;
            n = 0;
            while (n < 23) begin
                tx(1'b1, 1'b0, 1'b0);
                n++;
                if (n == 22) chk("t6_en_pre", 32'(ifa.locked), 32'd0);
                tx(1'b0, 1'b0, 1'b0);
                if (n == 22) chk("t6_en_hold", 32'(ifa.locked), 32'd0);
            end
            chk("t6_en_lock", 32'(ifa.locked), 32'd1);
        end

        // random traffic: errors, garbage bursts, clears, gated enable
        do_reset(2);
        for (int s = 0; s < 60; s++) begin
            int mode;
            mode = $urandom_range(0, 5);
            for (int i = 0; i < 70; i++) begin
                bit en, fl, cl;
                en = ($urandom_range(0, 3) != 0);
                cl = ($urandom_range(0, 150) == 0);
                unique case (1'b1)
                    (mode == 0): fl = 1'($urandom);
                    (mode == 1): fl = ($urandom_range(0, 6) == 0);
                    default:     fl = ($urandom_range(0, 60) == 0);
                endcase
                tx(en, fl, cl);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
